data_bus_machine: RTL



---
 rtl/data_bus_machine_if.sv | 46 ++++
 rtl/data_bus_machine.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/data_bus_machine_if.sv
// data_bus_machine_if: request handshake and device bus seen by one
// data_bus_machine instance.
//   decoder side : phi_1, phi_4, go, read, addr_in, wdata_in, err_clr
//   device side  : mem_rdata, mem_ready (in), mem_addr, mem_wdata,
//                  mem_rd, mem_wr (out)
//   status       : rdata, done, busy, stall, timeout_err, overrun_err
// The slave modport is the machine itself. The master modport is whatever
// drives the decoder and device side.
interface data_bus_machine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              phi_1;
  logic              phi_4;
  logic              go;
  logic              read;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              err_clr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;
  logic              stall;
  logic              timeout_err;
  logic              overrun_err;

  modport slave (
    input  phi_1, phi_4, go, read, addr_in, wdata_in, err_clr,
           mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_rd, mem_wr, rdata, done, busy, stall,
           timeout_err, overrun_err
  );

  modport master (
    output phi_1, phi_4, go, read, addr_in, wdata_in, err_clr,
           mem_rdata, mem_ready,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, rdata, done, busy, stall,
           timeout_err, overrun_err
  );
endinterface

// File: rtl/data_bus_machine.sv
// data_bus_machine: responder for the decoder go/read handshake. It performs
// one data-memory or port access per instruction cycle. It drives a
// registered address, strobe and write data, and captures read data into
// rdata. While a slow device holds mem_ready low, it asserts stall so the
// phase generator freezes. If the device never responds, the access is
// aborted after WAIT_MAX wait cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : data_bus_machine_if slave modport, carrying the request
//           handshake, the device bus and the status flags
// All outputs are registered.
module data_bus_machine #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 7
) (
  input  logic                clk,
  input  logic                reset,
  data_bus_machine_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_WAIT} state_t;

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr,  w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_read,  w_read;
  logic              r_rd,    w_rd;
  logic              r_wr,    w_wr;
  logic              r_done,  w_done;
  logic              r_busy,  w_busy;
  logic              r_stall, w_stall;
  logic              r_terr,  w_terr;
  logic              r_oerr,  w_oerr;
  logic [7:0]        r_cnt,   w_cnt;
  logic              w_cmpl;
  logic              w_abort;
  logic              w_ovr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_read  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_stall <= 1'b0;
      r_terr  <= 1'b0;
      r_oerr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_read  <= w_read;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_stall <= w_stall;
      r_terr  <= w_terr;
      r_oerr  <= w_oerr;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    w_read  = r_read;
    w_rd    = r_rd;
    w_wr    = r_wr;
    w_done  = 1'b0;
    w_busy  = r_busy;
    w_stall = r_stall;
    w_cnt   = r_cnt;
    w_cmpl  = 1'b0;
    w_abort = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.phi_1 && bus.go) begin
          w_addr = bus.addr_in;
          if (!bus.read) w_wdata = bus.wdata_in;
          w_read  = bus.read;
          w_busy  = 1'b1;
          w_state = S_ADDR;
        end
      end
      S_ADDR: begin
        w_rd    = r_read;
        w_wr    = !r_read;
        w_state = S_STROBE;
      end
      S_STROBE: begin
        if (bus.phi_4) begin
          if (bus.mem_ready) begin
            w_cmpl = 1'b1;
          end else begin
            w_state = S_WAIT;
            w_stall = 1'b1;
            w_cnt   = 8'd1;
          end
        end
      end
      S_WAIT: begin
        // Phases are frozen here, so the device is sampled on every edge.
        if (bus.mem_ready)     w_cmpl  = 1'b1;
        else if (r_cnt == WMAX) w_abort = 1'b1;
        else                   w_cnt   = r_cnt + 8'd1;
      end
      default: w_state = S_IDLE;
    endcase

    // Normal completion and timeout abort both close the access the same way.
    // They differ only in what lands in rdata.
    if (w_cmpl || w_abort) begin
      w_rd    = 1'b0;
      w_wr    = 1'b0;
      w_stall = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b1;
      w_cnt   = '0;
      w_state = S_IDLE;
    end
    if (w_cmpl && r_read) w_rdata = bus.mem_rdata;
    if (w_abort)          w_rdata = '0;

    // Sticky flags: a setting event in the same edge overrides err_clr.
    w_ovr  = bus.phi_1 && bus.go && r_busy;
    w_terr = w_abort | (r_terr & ~bus.err_clr);
    w_oerr = w_ovr   | (r_oerr & ~bus.err_clr);
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.mem_rd      = r_rd;
  assign bus.mem_wr      = r_wr;
  assign bus.rdata       = r_rdata;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;
  assign bus.stall       = r_stall;
  assign bus.timeout_err = r_terr;
  assign bus.overrun_err = r_oerr;

endmodule
